alu_req_arbiter: RTL

Two-requester arbiter and sequencer for the 16-bit ALU top. It accepts operation requests from two independent masters over valid/ready channels and grants the shared ALU round-robin. It drives the ALU's A/B/ALU_FUN inputs, waits out the ALU's one-cycle registered latency, and selects and checks the active unit's result. The formatted result is returned on a single tagged response channel.

---
 rtl/alu_req_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared 16-bit ALU: grants one request,
// drives the ALU operands, captures the active unit's result and returns it tagged.
module alu_req_arbiter #(
  parameter int OP_DATA_WIDTH = 16,
  parameter int RES_WIDTH     = 2 * OP_DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ0_VALID,
  output logic                     REQ0_READY,
  input  logic [OP_DATA_WIDTH-1:0] REQ0_A,
  input  logic [OP_DATA_WIDTH-1:0] REQ0_B,
  input  logic [3:0]               REQ0_FUN,
  input  logic                     REQ1_VALID,
  output logic                     REQ1_READY,
  input  logic [OP_DATA_WIDTH-1:0] REQ1_A,
  input  logic [OP_DATA_WIDTH-1:0] REQ1_B,
  input  logic [3:0]               REQ1_FUN,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic                     RSP_ID,
  output logic [RES_WIDTH-1:0]     RSP_DATA,
  output logic                     RSP_CARRY,
  output logic                     RSP_ERR,
  output logic [OP_DATA_WIDTH-1:0] ALU_A,
  output logic [OP_DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]               ALU_FUN,
  input  logic [RES_WIDTH-1:0]     Arith_OUT,
  input  logic                     Carry_OUT,
  input  logic                     Arith_Flag,
  input  logic [OP_DATA_WIDTH-1:0] Logic_OUT,
  input  logic                     Logic_Flag,
  input  logic [2:0]               CMP_OUT,
  input  logic                     CMP_Flag,
  input  logic [OP_DATA_WIDTH-1:0] Shift_OUT,
  input  logic                     Shift_Flag,
  output logic                     BUSY,
  output logic [1:0]               DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state;
  logic                 last_gnt;
  logic                 gnt;
  logic                 accept;
  logic [RES_WIDTH-1:0] cap_data;
  logic                 cap_carry;
  logic                 cap_err;

  // Valid/ready: a transfer happens on a rising CLK edge where VALID and READY are both
  // high; senders hold VALID and payload stable until then, and READY never depends on
  // anything but current state and the VALIDs.
  always_comb begin
    gnt = 1'b0;
    if (REQ0_VALID && REQ1_VALID) gnt = ~last_gnt;
    else if (REQ1_VALID)          gnt = 1'b1;
  end

  assign accept     = (state == ST_IDLE) && (REQ0_VALID || REQ1_VALID);
  assign REQ0_READY = (state == ST_IDLE) && REQ0_VALID && !gnt;
  assign REQ1_READY = (state == ST_IDLE) && REQ1_VALID &&  gnt;
  assign RSP_VALID  = (state == ST_RESP);
  assign BUSY       = (state != ST_IDLE);
  assign DBG_STATE  = state;

  // The ALU output is valid during WAIT; pick the unit named by the held function code.
  always_comb begin
    cap_data  = '0;
    cap_carry = 1'b0;
    cap_err   = 1'b0;
    case (ALU_FUN[3:2])
      2'b00: begin
        cap_data  = Arith_OUT;
        cap_carry = Carry_OUT;
        cap_err   = !Arith_Flag;
      end
      2'b01: begin
        cap_data = {{(RES_WIDTH-OP_DATA_WIDTH){1'b0}}, Logic_OUT};
        cap_err  = !Logic_Flag;
      end
      2'b10: begin
        cap_data = {{(RES_WIDTH-3){1'b0}}, CMP_OUT};
        cap_err  = !CMP_Flag;
      end
      default: begin
        cap_data = {{(RES_WIDTH-OP_DATA_WIDTH){1'b0}}, Shift_OUT};
        cap_err  = !Shift_Flag;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      last_gnt  <= 1'b1;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
      RSP_CARRY <= 1'b0;
      RSP_ERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_ISSUE;
            last_gnt <= gnt;
            RSP_ID   <= gnt;
            ALU_A    <= gnt ? REQ1_A   : REQ0_A;
            ALU_B    <= gnt ? REQ1_B   : REQ0_B;
            ALU_FUN  <= gnt ? REQ1_FUN : REQ0_FUN;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          RSP_DATA  <= cap_data;
          RSP_CARRY <= cap_carry;
          RSP_ERR   <= cap_err;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (RSP_READY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
